// File: rtl/ccl_window_gen_pkg.sv
// Shared constants and state encoding for the CCL neighbourhood window generator.
package ccl_window_gen_pkg;

  localparam int unsigned WORD_SIZE = 8;
  localparam int unsigned COORD_W   = 16;

  typedef enum logic [1:0] {
    CCLW_IDLE     = 2'd0,
    CCLW_PREFETCH = 2'd1,
    CCLW_EMIT     = 2'd2,
    CCLW_WAIT     = 2'd3
  } cclw_state_e;

endpackage

// File: rtl/ccl_window_gen_ram.sv
// Simple dual-port label store: one write port, one registered read port (1-cycle latency).
module ccl_window_gen_ram #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage is deliberately not cleared; the caller masks rows it has not written yet.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else if (re) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ccl_window_gen.sv
// Serial neighbourhood (A,B,C,D) generator feeding the connected-components labeller.
// One pixel in flight at a time so D always reflects the label just resolved.
module ccl_window_gen
  import ccl_window_gen_pkg::*;
#(
  parameter int unsigned WORD      = WORD_SIZE,
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned XW        = $clog2(IMG_WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [WORD-1:0]    pix,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               lbl_valid,
  input  logic [WORD-1:0]    lbl,
  input  logic [COORD_W-1:0] lbl_x,
  input  logic [COORD_W-1:0] lbl_y,
  output logic               win_valid,
  output logic [WORD-1:0]    A,
  output logic [WORD-1:0]    B,
  output logic [WORD-1:0]    C,
  output logic [WORD-1:0]    D,
  output logic [WORD-1:0]    p,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               lbl_err
);

  localparam int unsigned AW = XW + 1;
  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] WIDTH  = COORD_W'(IMG_WIDTH);

  cclw_state_e state, state_next;

  logic [WORD-1:0]    cur_p;
  logic [COORD_W-1:0] cur_x, cur_y;
  logic [WORD-1:0]    pre_q, b_q, c_q, last_lbl;
  logic [WORD-1:0]    ram_out;

  logic               accept_c, row_start_c, lbl_ok_c, lbl_bad_c;
  logic               rd_en_c, wr_en_c;
  logic [AW-1:0]      rd_addr_c, wr_addr_c;
  logic [WORD-1:0]    row_c, win_a_c, win_b_c, win_c_c, win_d_c;
  logic               unused_lbl_y;

  assign unused_lbl_y = ^lbl_y[COORD_W-1:1];

  assign accept_c    = pix_valid & pix_ready & (state == CCLW_IDLE);
  assign row_start_c = (pix_x == '0) & (pix_y != '0);
  assign lbl_ok_c    = lbl_valid & (state == CCLW_WAIT) & (lbl_x < WIDTH);
  assign lbl_bad_c   = lbl_valid & ~lbl_ok_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CCLW_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      CCLW_IDLE:     if (accept_c) state_next = row_start_c ? CCLW_PREFETCH : CCLW_EMIT;
      CCLW_PREFETCH: state_next = CCLW_EMIT;
      CCLW_EMIT:     state_next = CCLW_WAIT;
      CCLW_WAIT:     if (lbl_ok_c) state_next = CCLW_IDLE;
      default:       state_next = CCLW_IDLE;
    endcase
  end

  // Label-store control; the previous row always lives in bank ~y[0]
  always_comb begin
    rd_en_c   = 1'b0;
    rd_addr_c = '0;
    wr_en_c   = 1'b0;
    wr_addr_c = '0;
    case (state)
      CCLW_IDLE: begin
        if (accept_c) begin
          rd_en_c   = row_start_c | (pix_x != LAST_X);
          rd_addr_c = row_start_c ? {~pix_y[0], XW'(0)}
                                  : {~pix_y[0], pix_x[XW-1:0] + XW'(1)};
        end
      end
      CCLW_PREFETCH: begin
        rd_en_c   = 1'b1;
        rd_addr_c = {~cur_y[0], XW'(1)};
      end
      CCLW_WAIT: begin
        wr_en_c   = lbl_ok_c;
        wr_addr_c = {lbl_y[0], lbl_x[XW-1:0]};
      end
      default: ;
    endcase
  end

  // Window assembly; C past the right edge has no read behind it and is forced to 0
  always_comb begin
    row_c   = (cur_x == LAST_X) ? '0 : ram_out;
    win_a_c = '0;
    win_b_c = '0;
    win_c_c = '0;
    win_d_c = (cur_x == '0) ? '0 : last_lbl;
    if (cur_y != '0) begin
      if (cur_x == '0) begin
        win_b_c = pre_q;
        win_c_c = row_c;
      end else begin
        win_a_c = b_q;
        win_b_c = c_q;
        win_c_c = row_c;
      end
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_ready <= 1'b0;
      win_valid <= 1'b0;
      lbl_err   <= 1'b0;
      A         <= '0;
      B         <= '0;
      C         <= '0;
      D         <= '0;
      p         <= '0;
      x         <= '0;
      y         <= '0;
      cur_p     <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      pre_q     <= '0;
      b_q       <= '0;
      c_q       <= '0;
      last_lbl  <= '0;
    end else begin
      pix_ready <= (state_next == CCLW_IDLE);
      win_valid <= (state == CCLW_EMIT);
      if (lbl_bad_c) lbl_err <= 1'b1;
      if (accept_c) begin
        cur_p <= pix;
        cur_x <= pix_x;
        cur_y <= pix_y;
      end
      if (state == CCLW_PREFETCH) pre_q <= ram_out;
      if (state == CCLW_EMIT) begin
        A   <= win_a_c;
        B   <= win_b_c;
        C   <= win_c_c;
        D   <= win_d_c;
        p   <= cur_p;
        x   <= cur_x;
        y   <= cur_y;
        b_q <= win_b_c;
        c_q <= win_c_c;
      end
      if (lbl_ok_c) last_lbl <= lbl;
    end
  end

  ccl_window_gen_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(WORD)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .we     (wr_en_c),
    .wr_addr(wr_addr_c),
    .wr_data(lbl),
    .re     (rd_en_c),
    .rd_addr(rd_addr_c),
    .rd_data(ram_out)
  );

endmodule

// File: tb/tb_ccl_window_gen.sv
// Bench for ccl_window_gen: directed protocol steps plus randomized raster frames
// checked against a 2-D label image model.
module tb_ccl_window_gen;

  localparam int unsigned W  = 4;
  localparam int unsigned WD = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_valid, pix_ready;
  logic [WD-1:0] pix;
  logic [15:0]   pix_x, pix_y;
  logic          lbl_valid;
  logic [WD-1:0] lbl;
  logic [15:0]   lbl_x, lbl_y;
  logic          win_valid;
  logic [WD-1:0] A, B, C, D, p;
  logic [15:0]   x, y;
  logic          lbl_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Labels already returned by the labeller, indexed [row][col]
  logic [WD-1:0] lab [0:15][0:W-1];

  always #5 clk = ~clk;

  ccl_window_gen #(.WORD(WD), .IMG_WIDTH(W), .XW(2)) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix(pix), .pix_x(pix_x), .pix_y(pix_y),
    .lbl_valid(lbl_valid), .lbl(lbl), .lbl_x(lbl_x), .lbl_y(lbl_y),
    .win_valid(win_valid), .A(A), .B(B), .C(C), .D(D), .p(p), .x(x), .y(y),
    .lbl_err(lbl_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_label(input logic [WD-1:0] v, input int xx, input int yy);
    lbl_valid = 1'b1;
    lbl       = v;
    lbl_x     = 16'(xx);
    lbl_y     = 16'(yy);
    @(negedge clk);
    lbl_valid = 1'b0;
  endtask

  // Issue one pixel, check its window against the label image, then return its label
  task automatic do_pixel(input int xx, input int yy, input logic [WD-1:0] pv,
                          input logic [WD-1:0] lv, input int gap, input bit bad_first);
    int k;
    logic [WD-1:0] ea, eb, ec, ed;
    k = 0;
    while (!pix_ready && k < 20) begin @(negedge clk); k++; end
    check("ready_wait", 32'(pix_ready), 32'd1);
    pix_valid = 1'b1;
    pix       = pv;
    pix_x     = 16'(xx);
    pix_y     = 16'(yy);
    @(negedge clk);
    pix_valid = 1'b0;
    check("ready_drop", 32'(pix_ready), 32'd0);
    k = 1;
    while (!win_valid && k < 10) begin @(negedge clk); k++; end
    check("latency", 32'(k), (xx == 0 && yy > 0) ? 32'd3 : 32'd2);
    ea = (yy == 0 || xx == 0)     ? '0 : lab[yy-1][xx-1];
    eb = (yy == 0)                ? '0 : lab[yy-1][xx];
    ec = (yy == 0 || xx == W - 1) ? '0 : lab[yy-1][xx+1];
    ed = (xx == 0)                ? '0 : lab[yy][xx-1];
    check("win_A", 32'(A), 32'(ea));
    check("win_B", 32'(B), 32'(eb));
    check("win_C", 32'(C), 32'(ec));
    check("win_D", 32'(D), 32'(ed));
    check("win_p", 32'(p), 32'(pv));
    check("win_xy", {x, y}, {16'(xx), 16'(yy)});
    @(negedge clk);
    check("win_pulse", 32'(win_valid), 32'd0);
    check("ready_hold", 32'(pix_ready), 32'd0);
    repeat (gap) @(negedge clk);
    if (bad_first) begin
      check("err_clear", 32'(lbl_err), 32'd0);
      send_label(~lv, W, yy);
      check("err_range", 32'(lbl_err), 32'd1);
      check("err_stay_wait", 32'(pix_ready), 32'd0);
    end
    send_label(lv, xx, yy);
    check("ready_rise", 32'(pix_ready), 32'd1);
    lab[yy][xx] = lv;
  endtask

  initial begin
    int k;
    logic [WD-1:0] row0 [0:W-1];
    reset = 1'b1; pix_valid = 1'b0; pix = '0; pix_x = '0; pix_y = '0;
    lbl_valid = 1'b0; lbl = '0; lbl_x = '0; lbl_y = '0;

    // Reset held three cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 32'(pix_ready), 32'd0);
      check("rst_flags", {30'd0, win_valid, lbl_err}, 32'd0);
      check("rst_win", {A, B, C, D}, 32'd0);
      check("rst_pxy", {p, x[7:0], y[15:0]}, 32'd0);
    end
    reset = 1'b0;
    #1 check("ready_pre_edge", 32'(pix_ready), 32'd0);
    @(negedge clk);
    check("ready_after_rst", 32'(pix_ready), 32'd1);

    // Row 0 with labels [1,1,0,2], row 1 with (2,1)=5
    row0[0] = 8'd1; row0[1] = 8'd1; row0[2] = 8'd0; row0[3] = 8'd2;
    for (int c = 0; c < W; c++) do_pixel(c, 0, (c == 0) ? 8'd1 : 8'd0, row0[c], 0, 1'b0);
    do_pixel(0, 1, 8'd1, 8'd3, 1, 1'b0);
    do_pixel(1, 1, 8'd1, 8'd4, 0, 1'b0);
    do_pixel(2, 1, 8'd1, 8'd5, 2, 1'b0);
    do_pixel(3, 1, 8'd1, 8'd6, 0, 1'b0);
    check("edge_ABCD", {A, B, C, D}, {8'd0, 8'd2, 8'd0, 8'd5});

    // Stray label while IDLE
    check("err_idle_pre", 32'(lbl_err), 32'd0);
    send_label(8'hEE, 1, 1);
    check("err_idle", 32'(lbl_err), 32'd1);
    check("idle_ready", 32'(pix_ready), 32'd1);
    @(negedge clk);
    check("err_sticky", 32'(lbl_err), 32'd1);
    for (int c = 0; c < W; c++) do_pixel(c, 2, 8'(c & 1), 8'(10 + c), 0, 1'b0);
    check("err_sticky2", 32'(lbl_err), 32'd1);

    // Reset while waiting for a label
    k = 0;
    while (!pix_ready && k < 20) begin @(negedge clk); k++; end
    pix_valid = 1'b1; pix = 8'd1; pix_x = 16'd0; pix_y = 16'd3;
    @(negedge clk);
    pix_valid = 1'b0;
    k = 0;
    while (!win_valid && k < 10) begin @(negedge clk); k++; end
    check("pre_rst_win", 32'(win_valid), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_win", 32'(win_valid), 32'd0);
    check("midrst_err", 32'(lbl_err), 32'd0);
    check("midrst_ready", 32'(pix_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready_up", 32'(pix_ready), 32'd1);

    // Randomized raster frames; one out-of-range label mid-frame
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < W; c++)
          do_pixel(c, r, 8'($urandom_range(0, 1)), 8'($urandom_range(1, 255)),
                   int'($urandom_range(0, 2)), (f == 1 && r == 2 && c == 2));
    check("err_final", 32'(lbl_err), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
